// File: rtl/uart_tx_word_pkg.sv
// Shared definitions for the word-serialising UART transmitter.
package uart_tx_word_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } tx_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_BITS  = DATA_BITS * WORD_BYTES;

  // Integer clock cycles per line bit; the remainder is dropped.
  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_tx_word_if.sv
// Word-level handshake and line signals of the UART word transmitter.
interface uart_tx_word_if;
  import uart_tx_word_pkg::*;

  logic                 uart_tx_en;
  logic                 word_valid;
  logic [WORD_BITS-1:0] word_data;
  logic                 word_ready;
  logic                 uart_txd;
  logic                 uart_tx_busy;
  logic                 byte_done;
  logic                 word_done;

  modport master (
    output uart_tx_en, word_valid, word_data,
    input  word_ready, uart_txd, uart_tx_busy, byte_done, word_done
  );

  modport slave (
    input  uart_tx_en, word_valid, word_data,
    output word_ready, uart_txd, uart_tx_busy, byte_done, word_done
  );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: bit timing, byte FSM and the txd register.
// A byte offered while the previous frame is in its final cycle starts
// immediately, so consecutive bytes of a word have no extra idle clock.
module uart_tx_byte
  import uart_tx_word_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned BIT_RATE = 9600,
  parameter int unsigned GAP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_last,
  output logic                 o_ready,
  output logic                 o_txd,
  output logic                 o_byte_done,
  output logic                 o_word_done
);

  localparam int unsigned    CPB        = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned    CNT_W      = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]     GAP_LAST   = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

  tx_state_e            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2:0]           r_bit;
  logic [3:0]           r_gap;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_last;
  logic                 r_txd;
  logic                 r_byte_done;
  logic                 r_word_done;

  logic                 w_last_bit;
  logic                 w_frame_end;

  // Final mark bit-time of the frame: the stop bit when there is no gap.
  always_comb begin
    w_last_bit = 1'b0;
    if (GAP_BITS == 0) w_last_bit = (r_state == ST_STOP);
    else               w_last_bit = (r_state == ST_GAP) && (r_gap == GAP_LAST);
  end

  assign w_frame_end = w_last_bit && (r_cnt == '0);
  assign o_ready     = (r_state == ST_IDLE) || w_frame_end;
  assign o_txd       = r_txd;
  assign o_byte_done = r_byte_done;
  assign o_word_done = r_word_done;

  // Byte FSM with down-counting bit timer; done pulses are registered one
  // cycle early so they line up with the final cycle of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_gap       <= '0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_txd       <= 1'b1;
      r_byte_done <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      r_byte_done <= w_last_bit && (r_cnt == CNT_ONE);
      r_word_done <= w_last_bit && (r_cnt == CNT_ONE) && r_last;
      if (w_frame_end) begin
        if (i_valid) begin
          r_state <= ST_START;
          r_cnt   <= CNT_RELOAD;
          r_data  <= i_data;
          r_last  <= i_last;
          r_txd   <= 1'b0;
        end else begin
          r_state <= ST_IDLE;
          r_txd   <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_txd <= 1'b1;
            if (i_valid) begin
              r_state <= ST_START;
              r_cnt   <= CNT_RELOAD;
              r_data  <= i_data;
              r_last  <= i_last;
              r_txd   <= 1'b0;
            end
          end
          ST_START: begin
            if (r_cnt == '0) begin
              r_state <= ST_DATA;
              r_cnt   <= CNT_RELOAD;
              r_bit   <= '0;
              r_txd   <= r_data[0];
              r_data  <= {1'b0, r_data[DATA_BITS-1:1]};
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_DATA: begin
            if (r_cnt == '0) begin
              r_cnt <= CNT_RELOAD;
              if (r_bit == 3'd7) begin
                r_state <= ST_STOP;
                r_txd   <= 1'b1;
              end else begin
                r_bit  <= r_bit + 3'd1;
                r_txd  <= r_data[0];
                r_data <= {1'b0, r_data[DATA_BITS-1:1]};
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_STOP: begin
            if (r_cnt == '0) begin
              r_state <= ST_GAP;
              r_cnt   <= CNT_RELOAD;
              r_gap   <= '0;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_GAP: begin
            if (r_cnt == '0) begin
              r_cnt <= CNT_RELOAD;
              r_gap <= r_gap + 4'd1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_txd   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_tx_word.sv
// UART 8N1 word transmitter: sends a 32-bit word as four bytes, low byte first.
module uart_tx_word
  import uart_tx_word_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned BIT_RATE = 9600,
  parameter int unsigned GAP_BITS = 1
) (
  input logic          clk,
  input logic          rst,
  uart_tx_word_if.slave bus
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [WORD_BITS-1:0] r_shift;
  logic [1:0]           r_idx;
  logic                 r_busy;
  logic                 r_byte_valid;

  logic w_accept;
  logic w_byte_ready;
  logic w_byte_fire;
  logic w_txd;
  logic w_byte_done;
  logic w_word_done;

  // Word-level idle is tracked by busy, which drops on the edge the byte FSM
  // returns to IDLE after byte 3.
  assign bus.word_ready   = !r_busy && bus.uart_tx_en && !rst;
  assign w_accept         = bus.word_valid && bus.word_ready;
  assign w_byte_fire      = r_byte_valid && w_byte_ready;
  assign bus.uart_txd     = w_txd;
  assign bus.uart_tx_busy = r_busy;
  assign bus.byte_done    = w_byte_done;
  assign bus.word_done    = w_word_done;

  // Word latch, byte index and busy sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift      <= '0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_byte_valid <= 1'b0;
    end else if (w_accept) begin
      r_shift      <= bus.word_data;
      r_idx        <= '0;
      r_busy       <= 1'b1;
      r_byte_valid <= 1'b1;
    end else begin
      if (w_byte_fire) begin
        r_shift      <= {{DATA_BITS{1'b0}}, r_shift[WORD_BITS-1:DATA_BITS]};
        r_idx        <= r_idx + 2'd1;
        r_byte_valid <= (r_idx != LAST_IDX);
      end
      if (w_word_done) r_busy <= 1'b0;
    end
  end

  uart_tx_byte #(
    .CLK_HZ   (CLK_HZ),
    .BIT_RATE (BIT_RATE),
    .GAP_BITS (GAP_BITS)
  ) u_byte (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (r_byte_valid),
    .i_data      (r_shift[DATA_BITS-1:0]),
    .i_last      (r_idx == LAST_IDX),
    .o_ready     (w_byte_ready),
    .o_txd       (w_txd),
    .o_byte_done (w_byte_done),
    .o_word_done (w_word_done)
  );

endmodule

// File: tb/tb_uart_tx_word.sv
// Directed bench for uart_tx_word: 10 cycles/bit, one gap bit; a second
// instance covers the 9600 bit/s, no-gap configuration.
module tb_uart_tx_word;

  logic clk;
  logic rst;
  logic rst2;
  int unsigned n_cmp;
  int unsigned n_bad;

  uart_tx_word_if bus ();
  uart_tx_word_if bus2 ();

  uart_tx_word #(
    .CLK_HZ   (50000000),
    .BIT_RATE (5000000),
    .GAP_BITS (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  uart_tx_word #(
    .CLK_HZ   (50000000),
    .BIT_RATE (9600),
    .GAP_BITS (0)
  ) dut_slow (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {busy, txd, byte_done, word_done} n edges after acceptance
  // (10 cycles/bit, 110 cycles/byte); n=0 is the acceptance edge itself.
  function automatic logic [3:0] exp_line(input logic [31:0] w, input int n);
    int k, off, slot;
    logic [7:0] b;
    logic txd, bd, wd;
    if (n == 0) return 4'b1100;
    if (n < 0 || n > 440) return 4'b0100;
    k    = (n - 1) / 110;
    off  = (n - 1) % 110;
    slot = off / 10;
    b    = w[8*k +: 8];
    if (slot == 0)      txd = 1'b0;
    else if (slot <= 8) txd = b[slot-1];
    else                txd = 1'b1;
    bd = (off == 109);
    wd = bd && (k == 3);
    return {1'b1, txd, bd, wd};
  endfunction

  // Waits (bounded) for word_ready, then presents w for one accepting edge.
  task automatic start_word(input logic [31:0] w, input bit hold, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.word_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      bus.word_valid = 1'b1;
      bus.word_data  = w;
      tick();
      if (!hold) begin
        bus.word_valid = 1'b0;
        bus.word_data  = '0;
      end
    end
  endtask

  task automatic test_reset();
    logic [4:0] got;
    rst = 1'b1;
    bus.uart_tx_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      got = {bus.word_ready, bus.uart_tx_busy, bus.uart_txd, bus.byte_done, bus.word_done};
      n_cmp++;
      if (got !== 5'b00100) begin
        n_bad++;
        $display("FAIL reset_state cyc=%0d got=%b exp=00100", i, got);
      end
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.word_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready got=%b exp=1", bus.word_ready);
    end
  endtask

  task automatic test_single_word();
    logic [31:0] w = 32'hfe010113;
    logic [3:0] got, exp;
    bit ok;
    start_word(w, 1'b0, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL single_ready_timeout got=0 exp=1");
      return;
    end
    got = {bus.uart_tx_busy, bus.uart_txd, bus.byte_done, bus.word_done};
    n_cmp++;
    if (got !== 4'b1100) begin
      n_bad++;
      $display("FAIL single_accept got=%b exp=1100", got);
    end
    for (int n = 1; n <= 441; n++) begin
      tick();
      got = {bus.uart_tx_busy, bus.uart_txd, bus.byte_done, bus.word_done};
      exp = exp_line(w, n);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL single_line n=%0d got=%b exp=%b", n, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1 = 32'h00000000;
    logic [31:0] w2 = 32'hffffffff;
    logic [63:0] exp_bytes = 64'hffffffff_00000000;
    logic line_q[$];
    logic [7:0] rx_q[$];
    logic [3:0] got, exp;
    logic [7:0] rb;
    int i;
    bit ok;
    start_word(w1, 1'b1, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL b2b_ready_timeout got=0 exp=1");
      bus.word_valid = 1'b0;
      return;
    end
    bus.word_data = w2;
    line_q.push_back(1'b1);
    for (int n = 1; n <= 883; n++) begin
      tick();
      got = {bus.uart_tx_busy, bus.uart_txd, bus.byte_done, bus.word_done};
      exp = (n <= 441) ? exp_line(w1, n) : exp_line(w2, n - 442);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL b2b_line n=%0d got=%b exp=%b", n, got, exp);
      end
      if (n == 440 || n == 441 || n == 442) begin
        n_cmp++;
        if (bus.word_ready !== (n == 441)) begin
          n_bad++;
          $display("FAIL b2b_ready n=%0d got=%b exp=%b", n, bus.word_ready, (n == 441));
        end
      end
      if (n == 442) begin
        bus.word_valid = 1'b0;
        bus.word_data  = '0;
      end
      line_q.push_back(bus.uart_txd);
    end
    i = 1;
    while (i + 100 < line_q.size()) begin
      if (line_q[i] == 1'b0 && line_q[i-1] == 1'b1) begin
        for (int k = 0; k < 8; k++) rb[k] = line_q[i + 15 + 10*k];
        rx_q.push_back(rb);
        i += 95;
      end else begin
        i++;
      end
    end
    n_cmp++;
    if (rx_q.size() != 8) begin
      n_bad++;
      $display("FAIL b2b_rx_count got=%0d exp=8", rx_q.size());
    end
    for (int j = 0; j < 8; j++) begin
      rb = (j < rx_q.size()) ? rx_q[j] : 8'hxx;
      n_cmp++;
      if (rb !== exp_bytes[8*j +: 8]) begin
        n_bad++;
        $display("FAIL b2b_rx_byte j=%0d got=%h exp=%h", j, rb, exp_bytes[8*j +: 8]);
      end
    end
  endtask

  task automatic test_enable();
    logic [31:0] w = 32'h00100793;
    logic [3:0] got, exp;
    logic [2:0] g3;
    bit ok;
    start_word(w, 1'b0, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL en_ready_timeout got=0 exp=1");
      return;
    end
    for (int n = 1; n <= 441; n++) begin
      tick();
      got = {bus.uart_tx_busy, bus.uart_txd, bus.byte_done, bus.word_done};
      exp = exp_line(w, n);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL en_line n=%0d got=%b exp=%b", n, got, exp);
      end
      if (n == 150) begin
        bus.uart_tx_en = 1'b0;
        bus.word_valid = 1'b1;
        bus.word_data  = 32'hdeadbeef;
      end
    end
    for (int n = 0; n < 20; n++) begin
      tick();
      g3 = {bus.word_ready, bus.uart_tx_busy, bus.uart_txd};
      n_cmp++;
      if (g3 !== 3'b001) begin
        n_bad++;
        $display("FAIL en_hold n=%0d got=%b exp=001", n, g3);
      end
    end
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    bus.uart_tx_en = 1'b1;
    tick();
    n_cmp++;
    if (bus.word_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL en_restore_ready got=%b exp=1", bus.word_ready);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w  = 32'hfe010113;
    logic [31:0] w2 = 32'h00008067;
    logic [3:0] got, exp;
    logic [4:0] g5;
    bit ok;
    start_word(w, 1'b0, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rstmid_ready_timeout got=0 exp=1");
      return;
    end
    for (int n = 1; n <= 250; n++) begin
      tick();
      got = {bus.uart_tx_busy, bus.uart_txd, bus.byte_done, bus.word_done};
      exp = exp_line(w, n);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL rstmid_line n=%0d got=%b exp=%b", n, got, exp);
      end
    end
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      g5 = {bus.word_ready, bus.uart_tx_busy, bus.uart_txd, bus.byte_done, bus.word_done};
      n_cmp++;
      if (g5 !== 5'b00100) begin
        n_bad++;
        $display("FAIL rstmid_state n=%0d got=%b exp=00100", n, g5);
      end
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.word_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_release_ready got=%b exp=1", bus.word_ready);
    end
    start_word(w2, 1'b0, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rstmid_next_timeout got=0 exp=1");
      return;
    end
    for (int n = 1; n <= 441; n++) begin
      tick();
      got = {bus.uart_tx_busy, bus.uart_txd, bus.byte_done, bus.word_done};
      exp = exp_line(w2, n);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL rstmid_next n=%0d got=%b exp=%b", n, got, exp);
      end
    end
  endtask

  task automatic test_gap0_slow();
    int t_hi, t_bd, bd_cnt;
    logic txd_5208, txd_next;
    rst2 = 1'b0;
    tick();
    n_cmp++;
    if (bus2.word_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL gap0_ready got=%b exp=1", bus2.word_ready);
      rst2 = 1'b1;
      return;
    end
    bus2.word_valid = 1'b1;
    bus2.word_data  = 32'h000000a5;
    tick();
    bus2.word_valid = 1'b0;
    t_hi = -1;
    t_bd = -1;
    bd_cnt = 0;
    txd_5208 = 1'bx;
    txd_next = 1'bx;
    for (int n = 1; n <= 52081; n++) begin
      tick();
      if (t_hi < 0 && bus2.uart_txd === 1'b1) t_hi = n;
      if (bus2.byte_done === 1'b1) begin
        bd_cnt++;
        if (t_bd < 0) t_bd = n;
      end
      if (n == 5208) txd_5208 = bus2.uart_txd;
      if (n == 52081) txd_next = bus2.uart_txd;
    end
    n_cmp++;
    if (txd_5208 !== 1'b0) begin
      n_bad++;
      $display("FAIL gap0_start_held got=%b exp=0", txd_5208);
    end
    n_cmp++;
    if (t_hi != 5209) begin
      n_bad++;
      $display("FAIL gap0_bit_period got=%0d exp=5209", t_hi);
    end
    n_cmp++;
    if (t_bd != 52080) begin
      n_bad++;
      $display("FAIL gap0_frame_len got=%0d exp=52080", t_bd);
    end
    n_cmp++;
    if (bd_cnt != 1) begin
      n_bad++;
      $display("FAIL gap0_done_count got=%0d exp=1", bd_cnt);
    end
    n_cmp++;
    if (txd_next !== 1'b0) begin
      n_bad++;
      $display("FAIL gap0_next_start got=%b exp=0", txd_next);
    end
    rst2 = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst  = 1'b1;
    rst2 = 1'b1;
    bus.uart_tx_en  = 1'b0;
    bus.word_valid  = 1'b0;
    bus.word_data   = '0;
    bus2.uart_tx_en = 1'b1;
    bus2.word_valid = 1'b0;
    bus2.word_data  = '0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_enable();
    test_reset_mid_frame();
    test_gap0_slow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
